test_sequencer: RTL and testbench
=================================

TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 SHALL have parameter N_TESTS, default 6, meaning the number of test elements sequenced (range 1..32).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the max cycles a test may run before being declared hung (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin a sequence run; single-cycle pulse or level.
REQ-006 SHALL have port done  input  1  shared completion line from all test elements (pulled low when undriven).
REQ-007 SHALL have port fail  input  N_TESTS  per-test failure flags.
REQ-008 SHALL have port en  output  N_TESTS  one-hot (or zero) test enable.
REQ-009 SHALL have port busy  output  1  high from the first enable until the sequence is finished.
REQ-010 SHALL have port finished  output  1  high while holding results after the last test.
REQ-011 SHALL have port pass  output  1  valid when finished; high iff fail_mask and timeout_mask are both zero.
REQ-012 SHALL have port fail_mask  output  N_TESTS  latched fail[i] per completed test.
REQ-013 SHALL have port timeout_mask  output  N_TESTS  bit i set if test i hit TIMEOUT_CYCLES.
REQ-014 SHALL have port cur_index  output  clog2(N_TESTS) (min 1)  index of the active or last test.

Function
REQ-015 SHALL implement states IDLE, RUN, GAP, DONE; en nonzero only in RUN.
REQ-016 IDLE: start sampled high -> RUN next cycle, en=1<<0, cur_index=0, masks cleared, busy=1.
REQ-017 RUN: the cycle counter SHALL reset to 0 on entry and increment every cycle.
REQ-018 RUN: done sampled high -> fail_mask[cur_index]<=fail[cur_index]; en<=0; -> GAP (or DONE if cur_index==N_TESTS-1).
REQ-019 RUN: counter==TIMEOUT_CYCLES-1 with done low -> timeout_mask[cur_index]<=1, fail_mask bit unchanged, en<=0, same next state as REQ-018.
REQ-020 Done and timeout in the same cycle SHALL count as done; timeout bit not set.
REQ-021 GAP: SHALL hold en=0 until done sampled low, then cur_index+1, en=1<<(cur_index+1), -> RUN; GAP lasts >=1 cycle.
REQ-022 GAP SHALL also count cycles; reaching TIMEOUT_CYCLES-1 with done still high SHALL set timeout_mask[cur_index] and proceed as if done fell.
REQ-023 DONE: busy=0, finished=1, pass=~|(fail_mask|timeout_mask); outputs held until start or reset.
REQ-024 DONE with start high SHALL restart exactly as from IDLE (finished drops, masks clear).
REQ-025 start SHALL be ignored in RUN and GAP.
REQ-026 fail inputs SHALL only be sampled for the active index at done; other bits ignored.
REQ-027 N_TESTS==1 SHALL go IDLE->RUN->DONE with no GAP.

Reset
REQ-028 reset SHALL force IDLE, en=0, busy=0, finished=0, pass=0, masks=0, cur_index=0, counter=0.
REQ-029 reset SHALL override all other inputs, including mid-RUN and simultaneous start.

Structure
REQ-030 Package test_seq_pkg SHALL hold the state enum and the index-width function.
REQ-031 One sub-module, test_timeout_counter (clear, enable, expiry flag at TIMEOUT_CYCLES-1), SHALL be instantiated.

Verification (N_TESTS=4, TIMEOUT_CYCLES=16)
REQ-032 All 4 tests raise done 3 cycles after en, fail=0 -> en 0001,0010,0100,1000 in order; finished=1, pass=1, masks 0000.
REQ-033 Test 2 raises done with fail[2]=1 -> fail_mask=0100, pass=0, timeout_mask=0000.
REQ-034 Test 1 never raises done -> en=0010 held exactly 16 cycles; timeout_mask=0010, test 2 runs, pass=0.
REQ-035 done high on counter cycle 15 of test 0 -> timeout_mask=0000; done held high 20 cycles in GAP -> timeout_mask=0001, test 1 starts.
REQ-036 reset asserted while en=0100 -> next cycle en=0000, busy=0, masks 0; start then restarts at en=0001.
REQ-037 start pulsed during RUN -> no effect; start in DONE -> masks clear, en=0001 next cycle.

Source files
------------

// File: rtl/test_seq_pkg.sv
// Shared types and helpers for the test sequencer: FSM state encoding and index sizing.
package test_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    // Width of an index into n elements; a single element still needs one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/test_timeout_counter.sv
// Per-phase cycle counter: cleared on phase entry, flags expiry at TIMEOUT_CYCLES-1.
module test_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    // Saturates at the expiry value so the flag stays stable if the phase lingers.
    always_ff @(posedge clk) begin
        if (reset || clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + CW'(1);
    end

    assign expired = (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/test_sequencer.sv
// Runs N_TESTS test elements one at a time, collecting fail and timeout results per test.
module test_sequencer
    import test_seq_pkg::*;
#(
    parameter int N_TESTS        = 6,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            done,
    input  logic [N_TESTS-1:0]              fail,
    output logic [N_TESTS-1:0]              en,
    output logic                            busy,
    output logic                            finished,
    output logic                            pass,
    output logic [N_TESTS-1:0]              fail_mask,
    output logic [N_TESTS-1:0]              timeout_mask,
    output logic [idx_width(N_TESTS)-1:0]   cur_index
);

    localparam int IW = idx_width(N_TESTS);

    seq_state_e state, state_nxt;
    logic       tmo;
    logic       last;

    assign last = (cur_index == IW'(N_TESTS - 1));

    // Counter restarts on every state change, so RUN and GAP each time from zero.
    test_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_nxt != state),
        .enable (state == ST_RUN || state == ST_GAP),
        .expired(tmo)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (done || tmo) state_nxt = last ? ST_DONE : ST_GAP;
            ST_GAP:  if (!done || tmo) state_nxt = ST_RUN;
            ST_DONE: if (start) state_nxt = ST_RUN;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result capture; done wins over a coincident timeout in RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_index    <= '0;
            fail_mask    <= '0;
            timeout_mask <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        cur_index    <= '0;
                        fail_mask    <= '0;
                        timeout_mask <= '0;
                    end
                end
                ST_RUN: begin
                    if (done)
                        fail_mask[cur_index] <= fail[cur_index];
                    else if (tmo)
                        timeout_mask[cur_index] <= 1'b1;
                end
                ST_GAP: begin
                    if (!done || tmo) begin
                        if (done)
                            timeout_mask[cur_index] <= 1'b1;
                        cur_index <= cur_index + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        en       = '0;
        busy     = 1'b0;
        finished = 1'b0;
        pass     = 1'b0;
        case (state)
            ST_RUN: begin
                en   = N_TESTS'(1) << cur_index;
                busy = 1'b1;
            end
            ST_GAP:  busy = 1'b1;
            ST_DONE: begin
                finished = 1'b1;
                pass     = ~|(fail_mask | timeout_mask);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench: stimulus pushes expected enable windows and results, a monitor pops and compares.
module tb_test_sequencer;

    localparam int N  = 4;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         done = 1'b0;
    logic [N-1:0] fail = '0;
    logic [N-1:0] en, fail_mask, timeout_mask;
    logic         busy, finished, pass;
    logic [1:0]   cur_index;

    always #5 clk = ~clk;

    test_sequencer #(.N_TESTS(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .fail        (fail),
        .en          (en),
        .busy        (busy),
        .finished    (finished),
        .pass        (pass),
        .fail_mask   (fail_mask),
        .timeout_mask(timeout_mask),
        .cur_index   (cur_index)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit           is_res;
        logic [N-1:0] en;
        int           len;
        logic         pass;
        logic [N-1:0] fm;
        logic [N-1:0] tm;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Test-element model: done after dly[i] enabled cycles (0 = never), optionally held through GAP.
    int           dly[N];
    logic [N-1:0] fbits, junk, stick;
    int           cnt = 0;
    bit           hold = 0;

    always @(posedge clk) begin
        #1;
        fail = junk;
        if (en == '0) begin
            cnt = 0;
            if (!hold) done = 1'b0;
        end else begin
            int idx;
            idx = 0;
            for (int i = 0; i < N; i++) if (en[i]) idx = i;
            cnt++;
            if (dly[idx] != 0 && cnt == dly[idx]) begin
                done      = 1'b1;
                fail[idx] = fbits[idx];
                hold      = stick[idx];
            end else begin
                done = 1'b0;
                hold = 0;
            end
        end
    end

    // Monitor: closes each enable window and each finished rise against the queue.
    logic [N-1:0] prev_en = '0;
    bit           prev_fin = 0;
    int           run_len = 0;
    exp_t         me;

    always @(negedge clk) begin
        if (en !== prev_en) begin
            if (prev_en != '0 && !$isunknown(prev_en)) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_en actual=%b expected=none", prev_en);
                end else begin
                    me = q.pop_front();
                    chk("rec_kind_en", 0, me.is_res);
                    chk("en_value", prev_en, me.en);
                    chk("en_len", run_len, me.len);
                end
            end
            run_len = (en != '0) ? 1 : 0;
        end else if (en != '0) begin
            run_len++;
        end
        if (finished === 1'b1 && !prev_fin) begin
            if (q.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_finish actual=1 expected=none");
            end else begin
                me = q.pop_front();
                chk("rec_kind_res", 1, me.is_res);
                chk("res_pass", pass, me.pass);
                chk("res_fail_mask", fail_mask, me.fm);
                chk("res_timeout_mask", timeout_mask, me.tm);
                chk("res_busy", busy, 0);
                chk("res_cur_index", cur_index, N - 1);
            end
        end
        prev_en  = en;
        prev_fin = (finished === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_en(input logic [N-1:0] v, input int len);
        exp_t e;
        e.is_res = 0; e.en = v; e.len = len; e.pass = 0; e.fm = '0; e.tm = '0;
        q.push_back(e);
    endtask

    task automatic push_res(input logic p, input logic [N-1:0] fm, input logic [N-1:0] tm);
        exp_t e;
        e.is_res = 1; e.en = '0; e.len = 0; e.pass = p; e.fm = fm; e.tm = tm;
        q.push_back(e);
    endtask

    task automatic cfg(input int d0, input int d1, input int d2, input int d3,
                       input logic [N-1:0] fb, input logic [N-1:0] jk, input logic [N-1:0] st);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
        fbits = fb; junk = jk; stick = st;
    endtask

    task automatic push_normal4();
        for (int i = 0; i < N; i++) push_en(N'(1) << i, 3);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_en(input logic [N-1:0] v, input string name, output int n);
        n = 0;
        while (en !== v && n < 200) begin tick(); n++; end
        if (en !== v) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%b expected=%b", name, en, v);
        end
    endtask

    task automatic wait_finish(input string name);
        int n;
        n = 0;
        while (finished !== 1'b1 && n < 400) begin tick(); n++; end
        if (finished !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s_timeout actual=%b expected=1", name, finished);
        end
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cfg(3, 3, 3, 3, '0, '0, '0);
        repeat (3) tick();
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_finished", finished, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_mask", fail_mask, 0);
        chk("rst_timeout_mask", timeout_mask, 0);
        chk("rst_cur_index", cur_index, 0);
        reset = 1'b0;
        tick();

        // All tests pass
        cfg(3, 3, 3, 3, '0, '0, '0);
        push_normal4();
        push_res(1'b1, 4'b0000, 4'b0000);
        pulse_start();
        chk("s1_first_en", en, 4'b0001);
        chk("s1_busy", busy, 1);
        chk("s1_cur_index", cur_index, 0);
        wait_finish("s1");

        // Test 2 fails; non-active fail bits carry junk that must be ignored
        cfg(3, 3, 3, 3, 4'b0100, 4'b1011, '0);
        push_normal4();
        push_res(1'b0, 4'b0100, 4'b0000);
        pulse_start();
        wait_finish("s2");

        // Test 1 hangs: enable held for the full timeout, test 2 still runs
        cfg(3, 0, 3, 3, '0, '0, '0);
        push_en(4'b0001, 3);
        push_en(4'b0010, 16);
        push_en(4'b0100, 3);
        push_en(4'b1000, 3);
        push_res(1'b0, 4'b0000, 4'b0010);
        pulse_start();
        chk("s3_restart_fail_mask", fail_mask, 0);
        wait_finish("s3");

        // Done on the last RUN cycle counts as done; done stuck through GAP times out
        cfg(16, 3, 3, 3, '0, '0, 4'b0001);
        push_en(4'b0001, 16);
        push_en(4'b0010, 3);
        push_en(4'b0100, 3);
        push_en(4'b1000, 3);
        push_res(1'b0, 4'b0000, 4'b0001);
        pulse_start();
        chk("s4_restart_timeout_mask", timeout_mask, 0);
        chk("s4_restart_finished", finished, 0);
        chk("s4_restart_en", en, 4'b0001);
        wait_en(4'b0000, "s4_en0_fall", n);
        chk("s4_no_run_timeout", timeout_mask, 0);
        wait_en(4'b0010, "s4_en1", n);
        chk("s4_gap_len", n, 16);
        chk("s4_gap_timeout_mask", timeout_mask, 4'b0001);
        wait_finish("s4");

        // Start during RUN is ignored
        cfg(3, 3, 3, 3, '0, '0, '0);
        push_normal4();
        push_res(1'b1, 4'b0000, 4'b0000);
        pulse_start();
        wait_en(4'b0010, "s5_en1", n);
        pulse_start();
        chk("s5_start_in_run_idx", cur_index, 1);
        wait_finish("s5");

        // Reset mid-RUN with start also high
        cfg(3, 3, 0, 3, '0, '0, '0);
        push_en(4'b0001, 3);
        push_en(4'b0010, 3);
        push_en(4'b0100, 4);
        pulse_start();
        wait_en(4'b0100, "s6_en2", n);
        repeat (3) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("s6_rst_en", en, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_finished", finished, 0);
        chk("s6_rst_masks", {fail_mask, timeout_mask}, 0);
        chk("s6_rst_cur_index", cur_index, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("s6_idle_en", en, 0);
        cfg(3, 3, 3, 3, '0, '0, '0);
        push_normal4();
        push_res(1'b1, 4'b0000, 4'b0000);
        pulse_start();
        chk("s6_restart_en", en, 4'b0001);
        wait_finish("s6");

        repeat (3) tick();
        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
